bist_jtag_dr: RTL

//  TAP-side data-register front end for bist_test_module. Shifts BIST configuration in through
//  TDI and launches a BIST run with an ENABLE low-then-high sequence. Captures BIST_STATUS_REG

---
 rtl/bist_jtag_dr.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/bist_jtag_dr.sv
`default_nettype none
// ============================================================================
// Module      : bist_jtag_dr
// Description : TAP-side data-register front end for the BIST engine.
//               Shifts the BIST configuration in through TDI and launches a
//               run on each configuration update: ENABLE is held low for one
//               cycle, then held high. Captures the BIST status into a shift
//               chain and shifts it out on TDO. All logic runs on TCK.
// Options     : `define BIST_USER_DR_EN builds the BIST_USER data register.
//               Without it, SEL_USER is ignored and BIST_USER_TEST is tied
//               to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module bist_jtag_dr #(
    parameter int                CONF_W     = 13,
    parameter int                STAT_W     = 16,
    parameter int                USER_W     = 2052,
    parameter int                RUN_CYCLES = 16,
    parameter logic [CONF_W-1:0] CONF_RST   = 13'h0003
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SEL_CONF,
    input  logic              SEL_STATUS,
    input  logic              SEL_USER,
    input  logic              CAPTURE_DR,
    input  logic              SHIFT_DR,
    input  logic              UPDATE_DR,
    input  logic              TDI,
    output logic              TDO,
    output logic [CONF_W-1:0] BIST_CONF_REG,
    output logic [USER_W-1:0] BIST_USER_TEST,
    output logic              ENABLE,
    input  logic [STAT_W-1:0] BIST_STATUS_REG,
    output logic              BUSY
);

    // FSM encoding
    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_restart = 2'd1;
    localparam logic [1:0] c_st_run     = 2'd2;
    localparam logic [1:0] c_st_done    = 2'd3;

    // Last RUN count value. RUN_CYCLES is at most 65535, so the 16-bit
    // counter reaches its exit value without ever wrapping.
    localparam logic [15:0] c_cnt_last = 16'(RUN_CYCLES - 1);

    // ------------------------------------------------------------------
    // Register-select and strobe decode
    // ------------------------------------------------------------------
    logic w_sel_user_raw;

`ifdef BIST_USER_DR_EN
    assign w_sel_user_raw = SEL_USER;
`else
    // The user data register does not exist, so its select has no effect.
    logic w_unused_sel_user;
    assign w_sel_user_raw    = 1'b0;
    assign w_unused_sel_user = SEL_USER;
`endif

    // A chain acts only when its select is the single active one.
    logic w_sel_conf;
    logic w_sel_stat;
    logic w_sel_user;

    assign w_sel_conf = SEL_CONF & ~SEL_STATUS & ~w_sel_user_raw;
    assign w_sel_stat = SEL_STATUS & ~SEL_CONF & ~w_sel_user_raw;
    assign w_sel_user = w_sel_user_raw & ~SEL_CONF & ~SEL_STATUS;

    // Strobe priority: capture over shift, and shift over update.
    logic w_cap;
    logic w_shift;
    logic w_upd;
    logic w_upd_conf;

    assign w_cap      = CAPTURE_DR;
    assign w_shift    = SHIFT_DR & ~CAPTURE_DR;
    assign w_upd      = UPDATE_DR & ~CAPTURE_DR & ~SHIFT_DR;
    assign w_upd_conf = w_upd & w_sel_conf;

    // ------------------------------------------------------------------
    // Run-control FSM
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              w_run_exit;
    logic [15:0]       r_cnt;
    logic              r_done;
    logic [STAT_W-1:0] r_stat_q;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a configuration update restarts from any state, including mid-run
    always_comb begin
        w_state_nxt = r_state;
        w_run_exit  = 1'b0;
        if (w_upd_conf) begin
            w_state_nxt = c_st_restart;
        end else begin
            case (r_state)
                c_st_restart: w_state_nxt = c_st_run;
                c_st_run: begin
                    if (r_cnt == c_cnt_last) begin
                        w_state_nxt = c_st_done;
                        w_run_exit  = 1'b1;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Outputs: ENABLE is high in RUN and DONE; BUSY is high in RESTART and RUN
    always_comb begin
        ENABLE = 1'b0;
        BUSY   = 1'b0;
        case (r_state)
            c_st_restart: BUSY = 1'b1;
            c_st_run: begin
                ENABLE = 1'b1;
                BUSY   = 1'b1;
            end
            c_st_done: ENABLE = 1'b1;
            default: begin
                ENABLE = 1'b0;
                BUSY   = 1'b0;
            end
        endcase
    end

    // Run counter, done flag and status latch. Status is sampled only on a
    // completed run. An aborted run leaves the previous status in place.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_stat_q <= '0;
        end else begin
            if (w_state_nxt == c_st_restart) begin
                r_cnt  <= '0;
                r_done <= 1'b0;
            end else if (r_state == c_st_run) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_run_exit) begin
                r_stat_q <= BIST_STATUS_REG;
                r_done   <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Configuration chain and register
    // ------------------------------------------------------------------
    logic [CONF_W-1:0] r_conf_sr;
    logic [CONF_W-1:0] r_conf_reg;

    // Configuration shift chain: capture the live configuration, shift LSB first, update the register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_conf_sr  <= '0;
            r_conf_reg <= CONF_RST;
        end else if (w_sel_conf) begin
            if (w_cap) begin
                r_conf_sr <= r_conf_reg;
            end else if (w_shift) begin
                r_conf_sr <= {TDI, r_conf_sr[CONF_W-1:1]};
            end else if (w_upd) begin
                r_conf_reg <= r_conf_sr;
            end
        end
    end

    assign BIST_CONF_REG = r_conf_reg;

    // ------------------------------------------------------------------
    // Status chain: {done, busy, latched status}
    // ------------------------------------------------------------------
    logic [STAT_W+1:0] r_stat_sr;

    // Status shift chain: capture a snapshot of the run state, then shift it out
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stat_sr <= '0;
        end else if (w_sel_stat) begin
            if (w_cap) begin
                r_stat_sr <= {r_done, BUSY, r_stat_q};
            end else if (w_shift) begin
                r_stat_sr <= {TDI, r_stat_sr[STAT_W+1:1]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional user test-vector chain
    // ------------------------------------------------------------------
    logic w_user_lsb;

`ifdef BIST_USER_DR_EN
    logic [USER_W-1:0] r_user_sr;
    logic [USER_W-1:0] r_user_reg;

    // User vector chain: load on update only, without launching a run
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_user_sr  <= '0;
            r_user_reg <= '0;
        end else if (w_sel_user) begin
            if (w_cap) begin
                r_user_sr <= r_user_reg;
            end else if (w_shift) begin
                r_user_sr <= {TDI, r_user_sr[USER_W-1:1]};
            end else if (w_upd) begin
                r_user_reg <= r_user_sr;
            end
        end
    end

    assign BIST_USER_TEST = r_user_reg;
    assign w_user_lsb     = r_user_sr[0];
`else
    assign BIST_USER_TEST = '0;
    assign w_user_lsb     = w_sel_user;
`endif

    // ------------------------------------------------------------------
    // TDO
    // ------------------------------------------------------------------
    logic w_tdo_src;
    logic r_tdo;

    // Serial-out mux: LSB of the one selected chain, 0 if the selection is ambiguous or empty
    always_comb begin
        w_tdo_src = 1'b0;
        if (w_sel_conf) begin
            w_tdo_src = r_conf_sr[0];
        end else if (w_sel_stat) begin
            w_tdo_src = r_stat_sr[0];
        end else if (w_sel_user) begin
            w_tdo_src = w_user_lsb;
        end
    end

    // Registered TDO
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tdo <= 1'b0;
        end else begin
            r_tdo <= w_tdo_src;
        end
    end

    assign TDO = r_tdo;

endmodule
`default_nettype wire
